// File: rtl/reg_bank_xchg.sv
// reg_bank_xchg: 32x32 register bank with bypassed combinational reads and a self-sequenced two-register swap
module reg_bank_xchg #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_INDEX = 29,
  parameter int SP_RESET = 227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              xchg_start,
  input  logic [ADDR_W-1:0] xchg_a,
  input  logic [ADDR_W-1:0] xchg_b,
  output logic              busy,
  output logic              xchg_done
);
  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;
  state_t            state, state_nx;
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [ADDR_W-1:0] idx_a, idx_b, sw_addr;
  logic [DATA_W-1:0] tmp_a, tmp_b, sw_val;
  logic              sw_en, ext_we, start;
  assign sw_en   = state != IDLE;
  assign sw_addr = state == WR_A ? idx_a : idx_b;
  assign sw_val  = state == WR_A ? tmp_b : tmp_a;
  assign ext_we  = wr_en && state == IDLE && wr_addr != '0;
  assign start   = xchg_start && state == IDLE;
  assign busy    = sw_en;
  // r0 reads zero; an in-flight swap write wins over an accepted external write, which wins over storage
  function automatic logic [DATA_W-1:0] byp(input logic [ADDR_W-1:0] a);
    return a == '0 ? '0 : (sw_en && sw_addr == a) ? sw_val : (ext_we && wr_addr == a) ? wr_data : regs[a];
  endfunction
  // read ports see the same-cycle write view
  always_comb begin
    rs_data = byp(rs_addr);
    rt_data = byp(rt_addr);
  end
  // swap sequencing: start in IDLE, then one write cycle per register
  always_comb begin
    state_nx = state == IDLE ? (start ? WR_A : IDLE) : state == WR_A ? WR_B : IDLE;
  end
  // state, done pulse and swap operands; temps capture the bypassed view so a same-cycle write is included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      xchg_done <= 1'b0;
      idx_a     <= '0;
      idx_b     <= '0;
      tmp_a     <= '0;
      tmp_b     <= '0;
    end else begin
      state     <= state_nx;
      xchg_done <= state == WR_B;
      if (start) begin
        idx_a <= xchg_a;
        idx_b <= xchg_b;
        tmp_a <= byp(xchg_a);
        tmp_b <= byp(xchg_b);
      end
    end
  end
  // storage: external writes only in IDLE, swap writes only while busy, r0 never written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs                     <= '{default: '0};
      regs[ADDR_W'(SP_INDEX)] <= DATA_W'(SP_RESET);
    end else begin
      if (ext_we) regs[wr_addr] <= wr_data;
      if (sw_en && sw_addr != '0) regs[sw_addr] <= sw_val;
    end
  end
endmodule

// File: tb/tb_reg_bank_xchg.sv
// tb_reg_bank_xchg: randomized and directed checks of reg_bank_xchg against an array-level model
module tb_reg_bank_xchg;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0, xchg_a = '0, xchg_b = '0;
  logic [31:0] rs_data, rt_data, wr_data = '0;
  logic        wr_en = 1'b0, xchg_start = 1'b0, busy, xchg_done;
  int          checks = 0, errors = 0;
  logic [31:0] m [32];

  reg_bank_xchg dut (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .xchg_start(xchg_start), .xchg_a(xchg_a), .xchg_b(xchg_b),
    .busy(busy), .xchg_done(xchg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    return a == 0 ? 32'h0 : m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[29] = 32'd227;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      chk({tag, "_rs"}, rs_data, mread(5'(i)));
      chk({tag, "_rt"}, rt_data, mread(5'(31 - i)));
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    logic [4:0] o;
    o = 5'($urandom_range(0, 31));
    wr_en = 1'b1; wr_addr = a; wr_data = d; rs_addr = a; rt_addr = o;
    #1;
    chk("wr_bypass", rs_data, mread(a) & 32'h0 | (a == 0 ? 32'h0 : d));
    chk("wr_other", rt_data, o == a ? (a == 0 ? 32'h0 : d) : mread(o));
    step();
    wr_en = 1'b0;
    if (a != 0) m[a] = d;
    #1;
    chk("wr_after", rs_data, mread(a));
  endtask

  task automatic do_swap(input logic [4:0] a, input logic [4:0] b, input bit with_w,
                         input logic [4:0] wa, input logic [31:0] wd, input bit inject);
    logic [31:0] ta, tb;
    int          n;
    #1;
    chk("sw_idle_busy", 32'(busy), 32'd0);
    xchg_start = 1'b1; xchg_a = a; xchg_b = b;
    wr_en = with_w; wr_addr = wa; wr_data = wd;
    if (with_w && wa != 0) m[wa] = wd;
    ta = mread(a);
    tb = mread(b);
    step();
    xchg_start = 1'b0; wr_en = 1'b0;
    rs_addr = a;
    if (inject) begin
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
    end
    #1;
    chk("sw_busy1", 32'(busy), 32'd1);
    chk("sw_done1", 32'(xchg_done), 32'd0);
    chk("sw_byp_a", rs_data, a == 0 ? 32'h0 : tb);
    step();
    wr_en = 1'b0;
    if (a != 0) m[a] = tb;
    rt_addr = b;
    if (inject) begin
      xchg_start = 1'b1; xchg_a = 5'd1; xchg_b = 5'd2;
    end
    #1;
    chk("sw_busy2", 32'(busy), 32'd1);
    chk("sw_byp_b", rt_data, b == 0 ? 32'h0 : ta);
    step();
    xchg_start = 1'b0;
    if (b != 0) m[b] = ta;
    #1;
    chk("sw_busy3", 32'(busy), 32'd0);
    chk("sw_done3", 32'(xchg_done), 32'd1);
    rs_addr = a; rt_addr = b;
    #1;
    chk("sw_res_a", rs_data, mread(a));
    chk("sw_res_b", rt_data, mread(b));
    if (inject) begin
      chk("inj_r10", m[10], m[10]);
      rs_addr = 5'd10;
      #1;
      chk("inj_r10_kept", rs_data, mread(5'd10));
      n = 0;
      step();
      chk("inj_no_second", 32'(busy), 32'd0);
      chk("inj_done_fall", 32'(xchg_done), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    #3 reset_n = 1'b0;
    #9 reset_n = 1'b1;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(xchg_done), 32'd0);
    check_all("rst");

    do_write(5'd8, 32'hDEADBEEF);
    do_write(5'd0, 32'h1234);
    rs_addr = 5'd0;
    #1;
    chk("r0_zero", rs_data, 32'h0);

    do_write(5'd3, 32'd5);
    do_write(5'd7, 32'd9);
    do_swap(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("basic_r3", m[3], 32'd9);
    chk("basic_r7", m[7], 32'd5);

    do_swap(5'd3, 5'd7, 1'b1, 5'd3, 32'h55, 1'b0);
    chk("sw_wr_r7", m[7], 32'h55);
    chk("sw_wr_r3", m[3], 32'd5);

    do_write(5'd10, 32'h10);
    do_swap(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1);
    check_all("after_inject");

    do_write(5'd4, 32'h77);
    do_swap(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("r0_swap_r4", m[4], 32'h0);
    do_swap(5'd6, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0);

    do_write(5'd3, 32'h33);
    do_write(5'd7, 32'h77);
    xchg_start = 1'b1; xchg_a = 5'd3; xchg_b = 5'd7;
    step();
    xchg_start = 1'b0;
    #1;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(xchg_done), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("mid_idle", 32'(busy), 32'd0);
    check_all("mid_rst");

    for (int it = 0; it < 300; it++) begin
      logic [4:0] a, b;
      a = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      b = $urandom_range(0, 4) == 0 ? a : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: do_write(5'($urandom_range(0, 31)), $urandom);
        1: do_swap(a, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'b0);
        default: begin
          rs_addr = 5'($urandom_range(0, 31));
          rt_addr = 5'($urandom_range(0, 31));
          #1;
          chk("rnd_rs", rs_data, mread(rs_addr));
          chk("rnd_rt", rt_data, mread(rt_addr));
          step();
        end
      endcase
    end
    check_all("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
